// File: rtl/fir_pkg.sv
// Shared widths and the round/shift/saturate helper for the FIR decimating packer.
// Widths are fixed here; DECIM up to 8 keeps the accumulator inside ACC_W.
package fir_pkg;

    localparam int IN_W  = 20;
    localparam int OUT_W = 16;
    localparam int ACC_W = 23;

    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2**(OUT_W-1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(2**(OUT_W-1)));

    // Round half up, arithmetic shift, then clamp to the signed OUT_W range.
    function automatic logic [OUT_W-1:0] sat_round(input logic signed [ACC_W:0] sum,
                                                   input int shift);
        logic signed [ACC_W:0] half;
        logic signed [ACC_W:0] r;
        half = (ACC_W+1)'(1) <<< (shift - 1);
        r    = sum + half;
        r    = r >>> shift;
        if (r > SAT_MAX) begin
            return SAT_MAX[OUT_W-1:0];
        end else if (r < SAT_MIN) begin
            return SAT_MIN[OUT_W-1:0];
        end
        return r[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// DEPTH-entry FIFO with a registered head word; capacity counts the head entry.
// Writes land in storage first, so the head appears one cycle after the write.
module fir_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         rd_en_i,
    output logic [W-1:0] rd_data_o,
    output logic         valid_o,
    output logic         full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  head_q, head_d;
    logic          head_valid_q, head_valid_d;
    logic          pop, push, mem_has, load;

    assign full_o    = (cnt_q == CW'(DEPTH));
    assign valid_o   = head_valid_q;
    assign rd_data_o = head_valid_q ? head_q : '0;

    assign pop     = rd_en_i && head_valid_q;
    assign push    = wr_en_i && (!full_o || pop);
    assign mem_has = (cnt_q - CW'(head_valid_q)) != '0;
    assign load    = mem_has && (!head_valid_q || pop);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        head_d       = head_q;
        head_valid_d = head_valid_q;
        cnt_d        = cnt_q + CW'(push) - CW'(pop);
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (load) begin
            rd_ptr_d     = rd_ptr_q + AW'(1);
            head_d       = mem[rd_ptr_q];
            head_valid_d = 1'b1;
        end else if (pop) begin
            head_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            head_q       <= '0;
            head_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            head_q       <= head_d;
            head_valid_q <= head_valid_d;
        end
    end

endmodule

// File: rtl/fir_decim_packer.sv
// Integrate-and-dump decimator for the FIR output stream: accumulate DECIM samples,
// round/shift/saturate, stage, then push into a small output FIFO with drop accounting.
module fir_decim_packer
    import fir_pkg::*;
#(
    parameter int DECIM = 8,
    parameter int SHIFT = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             ovf,
    output logic [7:0]       drop_cnt
);
    localparam int PH_W = $clog2(DECIM);

    logic [PH_W-1:0]         phase_q, phase_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0]        stage_q, stage_d;
    logic                    stage_valid_q, stage_valid_d;
    logic                    ovf_q, ovf_d;
    logic [7:0]              drop_cnt_q, drop_cnt_d;

    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] sum;
    logic                    fifo_full, pop, push_req, push, drop;

    assign sample_ext = ACC_W'($signed(in_data));
    assign sum        = acc_q + sample_ext;

    assign pop      = out_valid && out_ready;
    // A clear in the hand-off cycle discards the staged word along with the partial sum.
    assign push_req = stage_valid_q && !clr;
    assign push     = push_req && (!fifo_full || pop);
    assign drop     = push_req && !push;

    always_comb begin
        phase_d       = phase_q;
        acc_d         = acc_q;
        stage_d       = stage_q;
        stage_valid_d = 1'b0;
        ovf_d         = ovf_q | drop;
        drop_cnt_d    = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
        if (clr) begin
            phase_d = '0;
            acc_d   = '0;
        end else if (in_valid) begin
            if (phase_q == PH_W'(DECIM - 1)) begin
                stage_d       = sat_round((ACC_W+1)'(sum), SHIFT);
                stage_valid_d = 1'b1;
                acc_d         = '0;
                phase_d       = '0;
            end else begin
                acc_d   = sum;
                phase_d = phase_q + PH_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q       <= '0;
            acc_q         <= '0;
            stage_q       <= '0;
            stage_valid_q <= 1'b0;
            ovf_q         <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            phase_q       <= phase_d;
            acc_q         <= acc_d;
            stage_q       <= stage_d;
            stage_valid_q <= stage_valid_d;
            ovf_q         <= ovf_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign ovf      = ovf_q;
    assign drop_cnt = drop_cnt_q;

    fir_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (OUT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (push),
        .wr_data_i (stage_q),
        .rd_en_i   (out_ready),
        .rd_data_o (out_data),
        .valid_o   (out_valid),
        .full_o    (fifo_full)
    );

endmodule

// File: tb/tb_fir_decim_packer.sv
// Bench for fir_decim_packer: vector table of 8-sample blocks plus hand sequences for
// latency, clear, overflow/drop, reset mid-burst and full-with-simultaneous-pop.
module tb_fir_decim_packer;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic [19:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        ovf;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        int base;
        int last;
        int exp;
    } vec_t;

    vec_t vecs[14];

    fir_decim_packer dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ovf       (ovf),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Scoreboard side: every accepted word is compared against the expected queue.
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: actual=%0d required=none", $signed(out_data));
                end else begin
                    check("word", int'($signed(out_data)), int'($signed(exp_q.pop_front())));
                end
            end else if (!out_valid) begin
                check("idle_zero", int'(out_data), 0);
            end
        end
    end

    task automatic drive_sample(input int v);
        in_valid = 1'b1;
        in_data  = 20'(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic send_block(input int base, input int last, input bit expect_word, input int exp);
        for (int i = 0; i < 7; i++) drive_sample(base);
        if (expect_word) exp_q.push_back(16'(exp));
        drive_sample(last);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_remaining", exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{base: 100,     last: 100,     exp: 100};
        vecs[1]  = '{base: -5,      last: -5,      exp: -5};
        vecs[2]  = '{base: 200000,  last: 200000,  exp: 32767};
        vecs[3]  = '{base: -200000, last: -200000, exp: -32768};
        vecs[4]  = '{base: 524287,  last: 524287,  exp: 32767};
        vecs[5]  = '{base: -524288, last: -524288, exp: -32768};
        vecs[6]  = '{base: 0,       last: 4,       exp: 1};
        vecs[7]  = '{base: 0,       last: 3,       exp: 0};
        vecs[8]  = '{base: 0,       last: -4,      exp: 0};
        vecs[9]  = '{base: 0,       last: -5,      exp: -1};
        vecs[10] = '{base: 32767,   last: 32768,   exp: 32767};
        vecs[11] = '{base: 32767,   last: 32775,   exp: 32767};
        vecs[12] = '{base: -32768,  last: -32769,  exp: -32768};
        vecs[13] = '{base: -32768,  last: -32773,  exp: -32768};

        rst       = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_drop_cnt", int'(drop_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Latency: out_valid rises only after the second edge following the last sample.
        send_block(100, 100, 1'b1, 100);
        @(negedge clk);
        check("lat_edge_n", int'(out_valid), 0);
        @(negedge clk);
        check("lat_edge_n1", int'(out_valid), 0);
        @(negedge clk);
        check("lat_edge_n2", int'(out_valid), 1);
        wait_drain(20);

        for (int i = 0; i < 14; i++) begin
            send_block(vecs[i].base, vecs[i].last, 1'b1, vecs[i].exp);
            // Gaps between samples must not disturb the phase.
            if (i == 5) repeat (3) @(posedge clk);
            #1;
        end
        wait_drain(40);

        // Clear discards the partial sum and the sample presented with it.
        for (int i = 0; i < 5; i++) drive_sample(50);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 20'd999;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        send_block(16, 16, 1'b1, 16);
        wait_drain(20);

        // Backpressure: five results into a four-entry FIFO, one dropped.
        out_ready = 1'b0;
        for (int b = 0; b < 5; b++) send_block(8, 8, b < 4, 8);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("ovf_set", int'(ovf), 1);
        check("drop_cnt_one", int'(drop_cnt), 1);
        check("hold_valid", int'(out_valid), 1);
        check("hold_data", int'($signed(out_data)), 8);
        @(negedge clk);
        check("hold_data_again", int'($signed(out_data)), 8);
        out_ready = 1'b1;
        wait_drain(20);
        repeat (5) @(negedge clk);
        check("no_extra_word", int'(out_valid), 0);
        check("ovf_sticky", int'(ovf), 1);

        // Reset in the middle of a burst with a word queued and ovf set.
        out_ready = 1'b0;
        send_block(100, 100, 1'b1, 100);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) drive_sample(50);
        rst = 1'b0;
        #2;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_out_data", int'(out_data), 0);
        check("mid_rst_ovf", int'(ovf), 0);
        check("mid_rst_drop_cnt", int'(drop_cnt), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        out_ready = 1'b1;
        send_block(7, 7, 1'b1, 7);
        wait_drain(20);

        // FIFO full, and the next result is written on the same cycle the head is popped.
        out_ready = 1'b0;
        for (int b = 0; b < 4; b++) send_block(8, 8, 1'b1, 8);
        send_block(9, 9, 1'b1, 9);
        out_ready = 1'b1;
        wait_drain(30);
        check("full_pop_ovf", int'(ovf), 0);
        check("full_pop_drop_cnt", int'(drop_cnt), 0);

        pulse_reset();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
